mw_writeback: RTL and testbench

- Stage 3 (memory/writeback) controller of the 3-stage RV32I pipeline.
- Produces the writeback triplet (rd_mw, rwe_mw, wb_data) that the stage-2 operand/forwarding logic consumes, and that also drives the regfile write port.
- Performs loads over a valid/ready data-cache handshake, extracts and extends the load data, and stalls upstream while a load is outstanding.

---
 rtl/mw_writeback.sv | 103 ++++++++++
 tb/tb_mw_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mw_writeback.sv
// mw_writeback: stage-3 memory/writeback controller with data-cache load handshake
module mw_writeback #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_x,
    input  logic [6:0]        opcode_x,
    input  logic [2:0]        funct3_x,
    input  logic [4:0]        rd_x,
    input  logic [XLEN-1:0]   alu_x,
    input  logic [XLEN-1:0]   pc4_x,
    output logic              dcache_req_valid,
    input  logic              dcache_req_ready,
    output logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_resp_valid,
    input  logic [XLEN-1:0]   dcache_dout,
    output logic [4:0]        rd_mw,
    output logic              rwe_mw,
    output logic [XLEN-1:0]   wb_data,
    output logic              stall
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              is_load, is_link, writes_rd;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_data;

    assign is_load   = opcode_x == OP_LOAD;
    assign is_link   = opcode_x == OP_JAL || opcode_x == OP_JALR;
    assign writes_rd = rd_x != 5'd0 && (opcode_x == OP_REG || opcode_x == OP_IMM || opcode_x == OP_LUI
                       || opcode_x == OP_AUIPC || is_link);
    assign stall            = state != IDLE;
    assign dcache_req_valid = state == REQ;
    assign dcache_addr      = {addr_q[ADDR_W-1:2], 2'b00};

    // Select the addressed byte/half of the returned word and extend per funct3 (bit 2 = unsigned)
    always_comb begin
        ld_byte   = dcache_dout[{addr_q[1:0], 3'b000} +: 8];
        ld_half   = dcache_dout[{addr_q[1], 4'b0000} +: 16];
        load_data = f3_q[1:0] == 2'd0 ? {{(XLEN-8){~f3_q[2] & ld_byte[7]}}, ld_byte}
                  : f3_q[1:0] == 2'd1 ? {{(XLEN-16){~f3_q[2] & ld_half[15]}}, ld_half}
                  : dcache_dout;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: a load leaves IDLE, waits for request acceptance, then for the response
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = valid_x && is_load ? REQ : IDLE;
            REQ:     state_nx = dcache_req_ready ? WAIT : REQ;
            WAIT:    state_nx = dcache_resp_valid ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Writeback registers and latched load fields; rwe_mw is a single-cycle pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_mw   <= '0;
            rwe_mw  <= 1'b0;
            wb_data <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
        end else begin
            rwe_mw <= 1'b0;
            if (state == IDLE && valid_x && is_load) begin
                addr_q <= alu_x[ADDR_W-1:0];
                f3_q   <= funct3_x;
                rd_q   <= rd_x;
            end else if (state == IDLE && valid_x) begin
                rd_mw   <= rd_x;
                rwe_mw  <= writes_rd;
                wb_data <= is_link ? pc4_x : alu_x;
            end else if (state == WAIT && dcache_resp_valid) begin
                rd_mw   <= rd_q;
                rwe_mw  <= rd_q != 5'd0;
                wb_data <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_mw_writeback.sv
// tb_mw_writeback: randomized self-checking bench for mw_writeback against a behavioural model
module tb_mw_writeback;
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011,
                           IMM = 7'b0010011, REG = 7'b0110011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111, BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_x = 1'b0;
    logic [6:0]  opcode_x = '0;
    logic [2:0]  funct3_x = '0;
    logic [4:0]  rd_x = '0;
    logic [31:0] alu_x = '0, pc4_x = '0;
    logic        dcache_req_valid, dcache_req_ready = 1'b0;
    logic [31:0] dcache_addr;
    logic        dcache_resp_valid = 1'b0;
    logic [31:0] dcache_dout = '0;
    logic [4:0]  rd_mw;
    logic        rwe_mw;
    logic [31:0] wb_data;
    logic        stall;

    int          n_cmp = 0, n_bad = 0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_wb = '0;

    mw_writeback dut (
        .clk(clk), .reset_n(reset_n), .valid_x(valid_x), .opcode_x(opcode_x), .funct3_x(funct3_x),
        .rd_x(rd_x), .alu_x(alu_x), .pc4_x(pc4_x), .dcache_req_valid(dcache_req_valid),
        .dcache_req_ready(dcache_req_ready), .dcache_addr(dcache_addr),
        .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout), .rd_mw(rd_mw),
        .rwe_mw(rwe_mw), .wb_data(wb_data), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_rwe"}, 32'(rwe_mw), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_req"}, 32'(dcache_req_valid), 32'd0);
        check({tag, "_rd"}, 32'(rd_mw), 32'(e_rd));
        check({tag, "_wb"}, wb_data, e_wb);
    endtask

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * addr[1:0]));
        h = 16'(word >> (addr[1] ? 16 : 0));
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    task automatic do_op(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4);
        logic wen;
        valid_x = 1'b1; opcode_x = op; funct3_x = 3'($urandom); rd_x = rd; alu_x = alu; pc4_x = pc4;
        step;
        wen = rd != 0 && (op inside {REG, IMM, LUI, AUIPC, JAL, JALR});
        e_rd = rd;
        e_wb = (op == JAL || op == JALR) ? pc4 : alu;
        check("op_rd", 32'(rd_mw), 32'(e_rd));
        check("op_rwe", 32'(rwe_mw), 32'(wen));
        check("op_wb", wb_data, e_wb);
        check("op_stall", 32'(stall), 32'd0);
        valid_x = 1'b0;
    endtask

    task automatic idle_cycle;
        valid_x = 1'b0; opcode_x = 7'($urandom); rd_x = 5'($urandom); alu_x = $urandom;
        step;
        chk_quiet("idle");
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] word, input int rdy_d, input int rsp_d, input bit spur);
        valid_x = 1'b1; opcode_x = LOAD; funct3_x = f3; rd_x = rd; alu_x = addr; pc4_x = $urandom;
        dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
        step;
        check("ld_issue_rwe", 32'(rwe_mw), 32'd0);
        check("ld_issue_stall", 32'(stall), 32'd1);
        check("ld_issue_req", 32'(dcache_req_valid), 32'd1);
        check("ld_issue_addr", dcache_addr, addr & ~32'd3);
        check("ld_issue_rd", 32'(rd_mw), 32'(e_rd));
        check("ld_issue_wb", wb_data, e_wb);
        for (int i = 0; i < rdy_d; i++) begin
            dcache_resp_valid = spur; dcache_dout = $urandom;
            step;
            check("ld_req_stall", 32'(stall), 32'd1);
            check("ld_req_valid", 32'(dcache_req_valid), 32'd1);
            check("ld_req_addr", dcache_addr, addr & ~32'd3);
            check("ld_req_rwe", 32'(rwe_mw), 32'd0);
        end
        dcache_req_ready = 1'b1; dcache_resp_valid = 1'b0;
        step;
        check("ld_wait_req", 32'(dcache_req_valid), 32'd0);
        check("ld_wait_stall", 32'(stall), 32'd1);
        dcache_req_ready = spur;
        for (int i = 1; i < rsp_d; i++) begin
            step;
            check("ld_wait_stall", 32'(stall), 32'd1);
            check("ld_wait_rwe", 32'(rwe_mw), 32'd0);
            check("ld_wait_req", 32'(dcache_req_valid), 32'd0);
        end
        dcache_resp_valid = 1'b1; dcache_dout = word; dcache_req_ready = 1'b0;
        step;
        e_rd = rd;
        e_wb = load_value(f3, addr, word);
        check("ld_rd", 32'(rd_mw), 32'(e_rd));
        check("ld_rwe", 32'(rwe_mw), 32'(rd != 0));
        check("ld_wb", wb_data, e_wb);
        check("ld_stall", 32'(stall), 32'd0);
        dcache_resp_valid = 1'b0; valid_x = 1'b0;
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{STORE, BRANCH, IMM, REG, LUI, AUIPC, JAL, JALR, BAD};
        #12;
        check("rst_rd", 32'(rd_mw), 32'd0);
        check("rst_rwe", 32'(rwe_mw), 32'd0);
        check("rst_wb", wb_data, 32'd0);
        check("rst_req", 32'(dcache_req_valid), 32'd0);
        check("rst_addr", dcache_addr, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        do_op(IMM, 5'd5, 32'h1234, 32'h4);
        idle_cycle;
        do_op(JAL, 5'd1, 32'hDEAD, 32'h104);
        do_op(STORE, 5'd7, 32'h55, 32'h108);
        do_op(REG, 5'd0, 32'h66, 32'h10C);
        idle_cycle;

        do_load(3'd0, 5'd9, 32'h1003, 32'h80FF_FF7F, 2, 3, 1'b0);
        check("lb_value", wb_data, 32'hFFFF_FF80);
        do_load(3'd5, 5'd10, 32'h2002, 32'h8001_1234, 0, 1, 1'b0);
        check("lhu_value", wb_data, 32'h0000_8001);
        do_load(3'd1, 5'd11, 32'h2002, 32'h8001_1234, 1, 2, 1'b1);
        check("lh_value", wb_data, 32'hFFFF_8001);
        do_load(3'd2, 5'd12, 32'h2002, 32'h8001_1234, 0, 1, 1'b0);
        check("lw_value", wb_data, 32'h8001_1234);
        do_load(3'd4, 5'd0, 32'h3001, 32'h0000_F300, 0, 2, 1'b0);

        dcache_resp_valid = 1'b1; dcache_req_ready = 1'b1;
        idle_cycle;
        dcache_resp_valid = 1'b0; dcache_req_ready = 1'b0;
        idle_cycle;

        valid_x = 1'b1; opcode_x = LOAD; funct3_x = 3'd2; rd_x = 5'd3; alu_x = 32'h40;
        step;
        dcache_req_ready = 1'b1;
        step;
        check("mid_wait_stall", 32'(stall), 32'd1);
        reset_n = 1'b0; valid_x = 1'b0; dcache_req_ready = 1'b0;
        #1;
        e_rd = '0; e_wb = '0;
        chk_quiet("mid_rst");
        check("mid_rst_addr", dcache_addr, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        dcache_resp_valid = 1'b1; dcache_dout = 32'hFFFF_FFFF;
        step;
        chk_quiet("late_resp");
        dcache_resp_valid = 1'b0;

        for (int n = 0; n < 80; n++) begin
            int r;
            logic [4:0] rd;
            r = $urandom_range(0, 11);
            rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            if (r < 4)
                do_load(3'($urandom), rd, $urandom, $urandom, $urandom_range(0, 3),
                        $urandom_range(1, 3), 1'($urandom));
            else if (r == 4)
                idle_cycle;
            else
                do_op(ops[$urandom_range(0, 8)], rd, $urandom, $urandom);
        end
        idle_cycle;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
